mux32_rr_arbiter: RTL and testbench
===================================

// Module: mux32_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares the 32:1 select datapath among 32 requesters.
//   Drives the mux select s[4:0] and enable, and issues a one-hot grant.
//   Paces transfers to a downstream sink with a valid/ready handshake.
//   Caps each grant at MAX_BURST beats so no requester starves the others.
// PARAMETERS
//   MAX_BURST  4  max beats (out_valid & out_ready) per grant; legal range 1..15
// PORTS
//   clk        input   1   rising-edge clock; the only clock
//   rst        input   1   asynchronous, active-high reset
//   req        input   32  level requests; bit i = requester i wants the datapath
//   out_ready  input   1   sink accepts the current beat
//   sel        output  5   mux select (s); index of the granted requester
//   en         output  1   mux enable; 1 only while a grant is held
//   gnt        output  32  one-hot grant; all-zero when idle
//   out_valid  output  1   mux output Y is valid this cycle (== en)
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, sel=0, en=0, gnt=0, out_valid=0,
//     ptr=0, beat_cnt=0. All outputs are registered.
//   State machine: IDLE -> GRANT -> RELEASE -> IDLE.
//   IDLE
//     - If req != 0, pick the first set bit at or above ptr, searching circularly:
//       ptr, ptr+1, ..., 31, 0, ..., ptr-1.
//     - Next edge: sel=winner, gnt=1<<winner, en=out_valid=1, beat_cnt=0,
//       state=GRANT. Latency from req to gnt is 1 cycle.
//     - If req == 0, stay in IDLE with outputs 0.
//   GRANT
//     - A beat occurs on a cycle with out_valid & out_ready; it increments beat_cnt.
//     - Release on the edge where either condition holds:
//       (a) req[sel]==0, sampled this cycle (drop wins even if a beat also occurs);
//       (b) a beat occurs and beat_cnt==MAX_BURST-1.
//     - On release: gnt=0, en=out_valid=0, ptr=sel+1 (mod 32, so 31 wraps to 0),
//       state=RELEASE.
//     - sel is held stable for the whole grant.
//     - Changes to other req bits are ignored (no preemption).
//     - out_ready low stalls: the grant is held and beat_cnt is unchanged.
//   RELEASE
//     - One dead cycle with all outputs 0, so the mux select settles before the
//       next enable. Then state=IDLE.
//     - Back-to-back grants therefore take 3 cycles per switch
//       (GRANT end -> RELEASE -> IDLE -> GRANT).
//   Fairness: the last winner has the lowest priority at the next arbitration.
//     A continuously requesting line waits at most 31 grants.
//   Reset mid-grant: outputs drop to 0 asynchronously. Any partial burst is
//     abandoned. ptr returns to 0.
//   Invariants
//     - gnt is one-hot or zero.
//     - en == out_valid == |gnt.
//     - gnt[sel]==1 whenever en==1.
//     - sel changes only while en==0.
// TESTING
//   1. Reset: assert rst mid-grant (gnt=0x4) -> same cycle gnt=0, en=0, sel=0;
//      after release, req=0x1 -> gnt=0x1 one cycle later.
//   2. Single requester burst: req=0x8, out_ready=1 held ->
//      gnt=0x8, sel=3 for exactly 4 beats, RELEASE, IDLE, then re-granted.
//   3. Round-robin and wrap: req=0x8000_0001 constant, out_ready=1 ->
//      grants alternate 0, 31, 0, 31 (ptr wraps 31->0).
//   4. Backpressure: req=0x10, out_ready toggles 1,0,0,1,1,1 ->
//      release only after the 4th accepted beat; sel=4 stable throughout.
//   5. Early drop: req=0x6 granted to bit 1; deassert req[1] after 2 beats ->
//      release next edge, then gnt=0x4 (sel=2) 2 cycles later.
//   6. Concurrency: randomized req/out_ready, 10k cycles -> all invariants hold;
//      no requester waits more than 31 grants.

Source files
------------

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter for a 32:1 select datapath: drives sel/en, a one-hot grant,
// and paces beats to a sink over out_valid/out_ready, capping each grant at MAX_BURST beats.
module mux32_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req,
  input  logic        out_ready,
  output logic [4:0]  sel,
  output logic        en,
  output logic [31:0] gnt,
  output logic        out_valid
);

  // Handshake: a beat is transferred on every cycle where out_valid & out_ready;
  // out_valid is held high for the whole grant and does not depend on out_ready.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  ptr;
  logic [3:0]  beat_cnt;

  logic        found;
  logic [4:0]  winner;
  logic [4:0]  idx;
  logic        beat;
  logic        last_beat;

  // Circular priority search starting at ptr; the descending loop lets the
  // smallest offset from ptr overwrite any later candidate.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int i = 31; i >= 0; i--) begin
      idx = ptr + 5'(i);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign beat      = out_valid & out_ready;
  assign last_beat = (beat_cnt == 4'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 5'd0;
      en        <= 1'b0;
      gnt       <= 32'd0;
      out_valid <= 1'b0;
      ptr       <= 5'd0;
      beat_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel       <= winner;
            gnt       <= 32'd1 << winner;
            en        <= 1'b1;
            out_valid <= 1'b1;
            beat_cnt  <= 4'd0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request releases even if a beat lands on the same edge.
          if (!req[sel] || (beat && last_beat)) begin
            gnt       <= 32'd0;
            en        <= 1'b0;
            out_valid <= 1'b0;
            sel       <= 5'd0;
            ptr       <= sel + 5'd1;
            beat_cnt  <= 4'd0;
            state     <= RELEASE;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        RELEASE: begin
          // Dead cycle so the mux select settles before the next enable.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Directed bench for mux32_rr_arbiter: reset, bursts, round-robin wrap, backpressure,
// early drop, then a random phase checking invariants, arbitration order and fairness.
module tb_mux32_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic        out_ready;
  logic [4:0]  sel;
  logic        en;
  logic [31:0] gnt;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  mux32_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .en        (en),
    .gnt       (gnt),
    .out_valid (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp_gnt, input logic [4:0] exp_sel);
    check({tag, "_gnt"}, gnt, exp_gnt);
    check({tag, "_sel"}, {27'd0, sel}, {27'd0, exp_sel});
    check({tag, "_en"}, {31'd0, en}, {31'd0, |exp_gnt});
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, |exp_gnt});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Full burst with out_ready high: 4 granted cycles, then RELEASE and IDLE at zero.
  task automatic run_grant(input string tag, input int w);
    for (int k = 0; k < 4; k++) begin
      step();
      expect_out(tag, 32'd1 << w, 5'(w));
    end
    step();
    expect_out({tag, "_rel"}, 32'd0, 5'd0);
    step();
    expect_out({tag, "_idle"}, 32'd0, 5'd0);
  endtask

  logic [3:0] bp_pat [6];
  int         wait_cnt [32];
  logic [4:0] ptr_m;
  logic [4:0] prev_sel;
  logic       prev_en;
  logic [4:0] exp_w;
  logic [4:0] cand;
  logic [31:0] flip;
  int         max_wait;

  initial begin
    rst = 1'b1;
    req = 32'd0;
    out_ready = 1'b0;
    @(negedge clk);
    expect_out("reset", 32'd0, 5'd0);
    rst = 1'b0;

    // 1. Reset mid-grant drops outputs asynchronously; ptr back to 0.
    req = 32'h4;
    out_ready = 1'b1;
    step();
    expect_out("pre_rst", 32'h4, 5'd2);
    step();
    rst = 1'b1;
    #1;
    expect_out("rst_async", 32'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 32'h1;
    step();
    expect_out("post_rst", 32'h1, 5'd0);

    // 2. Single requester: 4-beat burst, RELEASE, IDLE, re-grant.
    do_reset();
    req = 32'h8;
    out_ready = 1'b1;
    run_grant("burst_a", 3);
    run_grant("burst_b", 3);

    // 3. Round-robin alternation with 31 -> 0 wrap.
    do_reset();
    req = 32'h8000_0001;
    run_grant("rr0", 0);
    run_grant("rr1", 31);
    run_grant("rr2", 0);
    run_grant("rr3", 31);

    // 4. Backpressure: release only after the 4th accepted beat.
    do_reset();
    req = 32'h10;
    out_ready = 1'b1;
    bp_pat[0] = 1; bp_pat[1] = 0; bp_pat[2] = 0;
    bp_pat[3] = 1; bp_pat[4] = 1; bp_pat[5] = 1;
    step();
    for (int i = 0; i < 6; i++) begin
      expect_out("bp_hold", 32'h10, 5'd4);
      out_ready = bp_pat[i][0];
      step();
    end
    expect_out("bp_rel", 32'd0, 5'd0);

    // 5. Early drop after 2 beats, then bit 2 granted.
    do_reset();
    req = 32'h6;
    out_ready = 1'b1;
    step();
    expect_out("drop_g0", 32'h2, 5'd1);
    step();
    expect_out("drop_g1", 32'h2, 5'd1);
    step();
    expect_out("drop_g2", 32'h2, 5'd1);
    req = 32'h4;
    step();
    expect_out("drop_rel", 32'd0, 5'd0);
    step();
    expect_out("drop_idle", 32'd0, 5'd0);
    step();
    expect_out("drop_next", 32'h4, 5'd2);

    // 6. Random phase: invariants, arbitration order and bounded waiting.
    do_reset();
    req = 32'd0;
    ptr_m = 5'd0;
    prev_en = 1'b0;
    prev_sel = 5'd0;
    for (int i = 0; i < 32; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("inv_onehot", {31'd0, $onehot0(gnt)}, 32'd1);
      check("inv_en_valid", {31'd0, en}, {31'd0, out_valid});
      check("inv_en_gnt", {31'd0, en}, {31'd0, |gnt});
      if (en) check("inv_gnt_sel", {31'd0, gnt[sel]}, 32'd1);
      if (prev_en && en) check("inv_sel_hold", {27'd0, sel}, {27'd0, prev_sel});
      if (!prev_en && en) begin
        exp_w = ptr_m;
        for (int k = 31; k >= 0; k--) begin
          cand = ptr_m + 5'(k);
          if (req[cand]) exp_w = cand;
        end
        check("rr_winner", {27'd0, sel}, {27'd0, exp_w});
        max_wait = 0;
        for (int i = 0; i < 32; i++) begin
          if (i == int'(sel)) wait_cnt[i] = 0;
          else if (req[i]) wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
        check("fair_wait", {31'd0, max_wait > 31}, 32'd0);
      end
      if (prev_en && !en) ptr_m = prev_sel + 5'd1;
      prev_en = en;
      prev_sel = sel;

      flip = 32'd0;
      for (int i = 0; i < 32; i++) flip[i] = ($urandom_range(0, 15) == 0);
      req = req ^ flip;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 32; i++) if (!req[i]) wait_cnt[i] = 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
